// File: rtl/mcu_key_scanner.sv
// -----------------------------------------------------------------------------
// mcu_key_scanner
//   Autonomous key-matrix scanner and debouncer in front of the mcu core.
//   It drives one matrix column low at a time, senses the rows, and debounces
//   the complete matrix snapshot. When a key is newly pressed, the key code is
//   latched onto the core's port A input nibble. The status goes to port B.
//   Service is requested on the active-low _INT pin.
//
// Parameters
//   NCOLS        number of matrix columns (1..4)
//   DWELL        clk cycles each column is driven (>= 4)
//   DEBOUNCE     identical consecutive full scans needed to accept a change (1..15)
//   REPEAT_SCANS scans between auto-repeat events (only with KEY_REPEAT_EN)
//
// Ports
//   clk       system clock (shared with the mcu core)
//   reset     synchronous, active-high reset
//   row_n     raw row sense lines, active low, asynchronous to clk
//   col_n     column drive, active low, one-hot-low while scanning
//   int_ack   firmware acknowledge (a port E bit), sampled every clk
//   key_code  {col[1:0], row[1:0]} of the latched key (to prtAI)
//   key_stat  {pressed, multi, overrun, valid} (to prtBI)
//   _INT      interrupt request to the core, active low
//
// Optional feature
//   Define KEY_REPEAT_EN to generate the auto-repeat counter. If it is not
//   defined, a held key produces exactly one event.
//
// Service handshake
//   A press event sets valid and drives _INT low. If valid is still set when
//   the next press event arrives, the new key is dropped and overrun is set.
//   When int_ack is high in any cycle, valid and overrun clear and _INT
//   returns high on the next edge. If a press event lands in the same cycle
//   as int_ack, the press wins: the new code is latched, valid stays set,
//   overrun clears, and _INT stays low. _INT is always the registered ~valid.
// -----------------------------------------------------------------------------
module mcu_key_scanner #(
  parameter int NCOLS        = 4,
  parameter int DWELL        = 64,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_SCANS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_n,
  output logic [NCOLS-1:0] col_n,
  input  logic             int_ack,
  output logic [3:0]       key_code,
  output logic [3:0]       key_stat,
  output logic             _INT
);

  localparam int         NB        = NCOLS * 4;
  localparam int         DW        = $clog2(DWELL);
  localparam logic [1:0] LAST_COL  = 2'(NCOLS - 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);

  if (NCOLS < 1 || NCOLS > 4 || DWELL < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_SCANS < 1) begin : g_bad_params
    $error("mcu_key_scanner: illegal parameter value");
  end

  // Scan FSM: ST_SCAN walks the columns, ST_EVAL is the one-cycle debounce slot.
  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [1:0]    col_idx, col_idx_next;
  logic [DW-1:0] dwell_cnt, dwell_next;
  logic          sample;

  // Row synchronizer. It resets to all-ones, so no key is seen as closed.
  logic [3:0]    row_meta, row_sync;
  logic [3:0]    rows;

  // Matrix images, bit index = col*4 + row, 1 = key closed.
  logic [NB-1:0] snapshot, prev_snap, debounced;
  logic [3:0]    match_cnt, match_next;

  logic          pressed_q, multi_q, overrun_q, valid_q, int_n_q;
  logic [3:0]    code_q;

  logic          accept, press_evt, repeat_evt, any_evt, multi_new;
  logic [3:0]    first_idx, evt_code, code_next;
  logic          valid_next, overrun_next;

  assign rows = ~row_sync;

  // ---------------------------------------------------------------------------
  // Scan FSM, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    col_idx_next = col_idx;
    dwell_next   = dwell_cnt;
    sample       = 1'b0;
    case (state)
      ST_SCAN: begin
        if (dwell_cnt == LAST_DWELL) begin
          sample     = 1'b1;
          dwell_next = '0;
          if (col_idx == LAST_COL) begin
            state_next = ST_EVAL;
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end else begin
          dwell_next = dwell_cnt + DW'(1);
        end
      end
      ST_EVAL: begin
        state_next   = ST_SCAN;
        col_idx_next = 2'd0;
        dwell_next   = '0;
      end
      default: begin
        state_next   = ST_SCAN;
        col_idx_next = 2'd0;
        dwell_next   = '0;
      end
    endcase
  end

  // Column drive comes straight from the scan position. Reset overrides it,
  // so all columns stay high while reset is held. Column 0 is driven in the
  // very first cycle after release.
  always_comb begin
    col_n = '1;
    if (!reset && state == ST_SCAN) begin
      col_n = ~(NCOLS'(1) << col_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce and event decode (only meaningful in ST_EVAL)
  // ---------------------------------------------------------------------------
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;
  logic [3:0]    deb_idx;
  logic          deb_single;
  logic          rep_hit;
`endif

  always_comb begin
    if (snapshot == prev_snap) begin
      match_next = (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
    end else begin
      match_next = 4'd1;
    end

    // Lowest set bit is the lowest column, then the lowest row.
    first_idx = 4'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (snapshot[i]) first_idx = 4'(i);
    end
    multi_new = |(snapshot & (snapshot - NB'(1)));

    accept    = (state == ST_EVAL) && (match_next == 4'(DEBOUNCE)) &&
                (snapshot != debounced);
    press_evt = accept && (debounced == '0);

    repeat_evt = 1'b0;
`ifdef KEY_REPEAT_EN
    deb_idx = 4'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (debounced[i]) deb_idx = 4'(i);
    end
    deb_single = (debounced != '0) && !(|(debounced & (debounced - NB'(1))));
    rep_hit    = deb_single && (deb_idx == code_q);
    repeat_evt = (state == ST_EVAL) && !accept && rep_hit &&
                 (rep_cnt == RW'(REPEAT_SCANS - 1));
`endif

    any_evt  = press_evt || repeat_evt;
    evt_code = press_evt ? first_idx : code_q;

    valid_next   = valid_q;
    overrun_next = overrun_q;
    code_next    = code_q;
    if (int_ack) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
    if (any_evt) begin
      // A press is dropped only when the previous one is still unserviced.
      if (valid_q && !int_ack) begin
        overrun_next = 1'b1;
      end else begin
        code_next    = evt_code;
        valid_next   = 1'b1;
        overrun_next = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      snapshot  <= '0;
      prev_snap <= '0;
      debounced <= '0;
      match_cnt <= 4'd0;
      pressed_q <= 1'b0;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= 4'd0;
      int_n_q   <= 1'b1;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      dwell_cnt <= dwell_next;
      row_meta  <= row_n;
      row_sync  <= row_meta;

      if (sample) begin
        for (int c = 0; c < NCOLS; c++) begin
          if (col_idx == 2'(c)) snapshot[c*4 +: 4] <= rows;
        end
      end

      if (state == ST_EVAL) begin
        prev_snap <= snapshot;
        match_cnt <= match_next;
      end

      if (accept) begin
        debounced <= snapshot;
        pressed_q <= (snapshot != '0);
        multi_q   <= multi_new;
      end

      valid_q   <= valid_next;
      overrun_q <= overrun_next;
      code_q    <= code_next;
      int_n_q   <= ~valid_next;
    end
  end

`ifdef KEY_REPEAT_EN
  // Counts scans while the single held key is the latched one. Any accepted
  // matrix change restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (state == ST_EVAL) begin
      if (accept || !rep_hit || repeat_evt) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end
`endif

  assign key_code = code_q;
  assign key_stat = {pressed_q, multi_q, overrun_q, valid_q};
  assign _INT     = int_n_q;

endmodule

// File: doc/mcu_key_scanner.md
Name: mcu_key_scanner

Overview:
- Autonomous key-matrix scanner and debouncer sitting directly upstream of the mcu core.
- Drives matrix columns and senses rows, then debounces the whole matrix.
- Presents a latched key code on the core's port A/B input nibbles (prtAI/prtBI) and requests service on the core's active-low _INT pin.
- Relieves firmware of scan and debounce loops; firmware reads the ports via ip and acknowledges through one output-port bit.

Parameters:
- NCOLS, 4, number of matrix columns, legal 1..4.
- DWELL, 64, clk cycles each column is driven, legal >= 4.
- DEBOUNCE, 3, consecutive identical full scans needed to accept a matrix change, legal 1..15.
- REPEAT_SCANS, 32, scans between auto-repeat events; used only with the optional feature.

Ports:
- clk  in  1  system clock (same clock as the mcu core).
- reset  in  1  synchronous, active-high reset.
- row_n  in  4  raw row sense lines, active low, asynchronous.
- col_n  out  NCOLS  column drive, active low, one-hot-low.
- int_ack  in  1  acknowledge from firmware (a port E bit), sampled every clk.
- key_code  out  4  to prtAI: {col[1:0], row[1:0]} of the latched key.
- key_stat  out  4  to prtBI: {pressed, multi, overrun, valid}.
- _INT  out  1  interrupt request to the core, active low.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`. All state changes on posedge clk.
- Reset values: col_n = all ones, key_code = 0, key_stat = 0, _INT = 1. All counters, snapshot, debounced matrix and match count are cleared. Reset mid-scan aborts the scan with no event.
- Input sync: row_n passes through a 2-flop synchronizer. Internal row = ~synced row_n (1 = key closed).
- FSM states:
  - SCAN: drive col_n[k] low for DWELL cycles. Sample synced rows into snapshot[k] on the last dwell cycle. Then k+1; after column NCOLS-1 go to EVAL.
  - EVAL: one cycle with all columns high. Then k = 0 and back to SCAN.
  - Scan period P = NCOLS*DWELL + 1 cycles. First column 0 drive is the first cycle after reset deasserts.
- Debounce (in EVAL):
  - If snapshot == previous snapshot, match_cnt increments, saturating at 15. Otherwise match_cnt = 1.
  - Previous snapshot is updated every EVAL.
  - Accept when match_cnt == DEBOUNCE and snapshot != debounced; then debounced <= snapshot.
- Events on accept:
  - pressed = (debounced != 0).
  - Press event: old debounced == 0 and new != 0. Select the lowest-index closed key, column-major (lowest col, then lowest row).
    - If valid == 0: key_code <= code, multi <= (more than one key closed), valid <= 1, _INT <= 0.
    - If valid == 1: key_code is unchanged and overrun <= 1.
  - Key-to-key changes while still pressed and releases only update pressed and multi; no interrupt.
- Acknowledge:
  - int_ack high in any cycle clears valid and overrun and sets _INT to 1 on the next edge.
  - Same cycle as a press event: the press wins. valid = 1, new key_code, overrun = 0, _INT = 0.
- _INT is registered, glitch-free, and equals ~valid.
- Width rules: key_code col field = column index (bits beyond NCOLS are never produced). key_stat bits are individually registered.

Optional Feature:
- KEY_REPEAT_EN defined:
  - While debounced holds exactly one key and that key equals the latched key_code, a repeat counter counts EVAL cycles.
  - Every REPEAT_SCANS scans it issues a press event through the same valid/overrun/_INT rules.
  - Counter clears on any debounced change or reset.
- KEY_REPEAT_EN undefined: no repeat logic is generated, REPEAT_SCANS is ignored, and a held key yields exactly one event.

Test Plan:
- Reset with params NCOLS=4, DWELL=4, DEBOUNCE=3 -> col_n=4'b1111, _INT=1, key_stat=0 during reset. col_n=4'b1110 on the first cycle after release; col_n rotates every 4 cycles; P=17.
- Close the key at col 2, row 1 steadily -> _INT falls within 3 scans plus sync (<= 3*17+3 cycles). key_code=4'b1001, key_stat=4'b1001.
- Bounce: the key toggles every 10 cycles for 100 cycles, then opens -> _INT stays 1, key_stat stays 0.
- Close col 0 row 3 plus col 1 row 0 together -> key_code=4'b0011, key_stat=4'b1101. Pulse int_ack -> key_stat=4'b1100, _INT=1 next cycle.
- No ack; release, then close col 3 row 2 -> key_code stays 4'b0011, overrun=1. Assert int_ack in the exact EVAL cycle of a further press event -> valid=1, overrun=0, new code latched, _INT=0.
- With KEY_REPEAT_EN, REPEAT_SCANS=2, hold col 1 row 1 and ack each event -> _INT re-asserts every 2 scans with key_code=4'b0101. Without the macro -> a single event only.
